// File: rtl/rpi_rx_pkg.sv
// Shared types and defaults for the RPi parallel-bus receive controller.
package rpi_rx_pkg;

    localparam int unsigned      RX_DW         = 16;
    localparam logic [RX_DW-1:0] DEF_SYNC_WORD = 16'hA55A;
    localparam int unsigned      DEF_FRAME_LEN = 256;
    localparam int unsigned      DEF_LO_WM     = 512;
    localparam int unsigned      DEF_HI_WM     = 768;

    // Parser state: hunting for a sync word, inside a frame, or expecting the next sync.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        CHECK  = 2'd2
    } rx_state_t;

    // One skid-buffer slot: payload word plus frame markers.
    typedef struct packed {
        logic [RX_DW-1:0] data;
        logic             sof;
        logic             eof;
    } rx_entry_t;

endpackage

// File: rtl/rpi_rx_skid.sv
// Two-entry valid/ready buffer for framed words. The entry count is exported
// so the read sequencer can issue FIFO reads only when a slot is guaranteed.
module rpi_rx_skid
    import rpi_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rx_entry_t  push_entry,
    input  logic       ready,
    output rx_entry_t  head,
    output logic       valid,
    output logic [1:0] count
);

    rx_entry_t ent0;
    rx_entry_t ent1;
    logic      pop;

    assign valid = (count != 2'd0);
    assign pop   = valid & ready;
    // Head is forced to zero when empty so the stream outputs read 0 after reset.
    assign head  = valid ? ent0 : '0;

    // Occupancy counter; push and pop in the same cycle leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
        end else if (push && !pop) begin
            count <= count + 2'd1;
        end else if (pop && !push) begin
            count <= count - 2'd1;
        end
    end

    // Storage: ent0 is always the head, ent1 the entry behind it.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (push && count == 2'd1) begin
                ent0 <= push_entry;
            end else begin
                ent0 <= ent1;
            end
            if (push && count == 2'd2) begin
                ent1 <= push_entry;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                ent0 <= push_entry;
            end else begin
                ent1 <= push_entry;
            end
        end
    end

endmodule

// File: rtl/rpi_rx_ctrl.sv
// Read-side controller for the RPi receive FIFO: hysteresis flow control to
// the RPi, credit-based FIFO reads with 1-cycle read latency, sync-word frame
// parser and a valid/ready output stream with SOF/EOF markers.
// Optional macro RPI_RX_STATS_EN adds saturating frame_cnt and sync_err_cnt.
module rpi_rx_ctrl
    import rpi_rx_pkg::*;
#(
    parameter int unsigned   DW        = RX_DW,
    parameter int unsigned   AW        = 10,
    parameter int unsigned   LO_WM     = DEF_LO_WM,
    parameter int unsigned   HI_WM     = DEF_HI_WM,
    parameter logic [DW-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int unsigned   FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] fifo_q,
    input  logic          fifo_rdempty,
    input  logic          fifo_rdfull,
    input  logic [AW-1:0] fifo_rdusedw,
    output logic          fifo_rdreq,
    output logic          rpi_req,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_sof,
    output logic          m_eof,
    input  logic          m_ready,
    output logic          locked,
`ifdef RPI_RX_STATS_EN
    output logic [15:0]   frame_cnt,
    output logic [7:0]    sync_err_cnt,
`endif
    output logic          overflow
);

    localparam logic [AW:0] LO_LVL   = LO_WM[AW:0];
    localparam logic [AW:0] HI_LVL   = HI_WM[AW:0];
    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    logic [AW:0] fullness_p1;
    logic        inflight_p1;
    logic [1:0]  buf_count;
    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [15:0] idx;
    logic [15:0] idx_nxt;
    logic        push;
    rx_entry_t   push_entry;
    rx_entry_t   head;
    logic        word_is_sync;

    // A read is only issued when the buffer can absorb it plus any word already in flight.
    assign fifo_rdreq   = ~rst & enable & ~fifo_rdempty &
                          (({1'b0, buf_count} + {2'b00, inflight_p1}) < 3'd2);
    assign word_is_sync = (fifo_q == SYNC_WORD);
    assign locked       = (state != HUNT);

    // Stage p1: registered fullness, read-in-flight flag, flow control and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            fullness_p1 <= '0;
            inflight_p1 <= 1'b0;
            rpi_req     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            fullness_p1 <= {fifo_rdfull, fifo_rdusedw};
            inflight_p1 <= fifo_rdreq;
            overflow    <= overflow | fullness_p1[AW];
            if (!enable) begin
                rpi_req <= 1'b0;
            end else if (fullness_p1 < LO_LVL) begin
                rpi_req <= 1'b1;
            end else if (fullness_p1 >= HI_LVL) begin
                rpi_req <= 1'b0;
            end
        end
    end

    // Parser state register and in-frame word index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Parser next state: steps once per captured word, pushes payload words only.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        push            = 1'b0;
        push_entry.data = fifo_q;
        push_entry.sof  = (idx == 16'd0);
        push_entry.eof  = (idx == LAST_IDX);
        if (inflight_p1) begin
            case (state)
                HUNT: begin
                    if (word_is_sync) begin
                        state_nxt = LOCKED;
                        idx_nxt   = '0;
                    end
                end
                LOCKED: begin
                    push = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nxt = CHECK;
                    end else begin
                        idx_nxt = idx + 16'd1;
                    end
                end
                CHECK: begin
                    idx_nxt = '0;
                    if (word_is_sync) begin
                        state_nxt = LOCKED;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    rpi_rx_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .ready      (m_ready),
        .head       (head),
        .valid      (m_valid),
        .count      (buf_count)
    );

    assign m_data = head.data;
    assign m_sof  = head.sof;
    assign m_eof  = head.eof;

`ifdef RPI_RX_STATS_EN
    logic sync_err;
    assign sync_err = inflight_p1 & (state == CHECK) & ~word_is_sync;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Saturating frame and sync-error event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt    <= '0;
            sync_err_cnt <= '0;
        end else begin
            if (push && push_entry.eof) begin
                frame_cnt <= sat_inc16(frame_cnt);
            end
            if (sync_err) begin
                sync_err_cnt <= sat_inc8(sync_err_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rpi_rx_ctrl.sv
// Self-checking bench for rpi_rx_ctrl: a queue-based FIFO model feeds the DUT,
// and a word-level frame model predicts the output stream and control outputs.
module tb_rpi_rx_ctrl;

    localparam int          L    = 256;
    localparam logic [15:0] SYNC = 16'hA55A;
    localparam int          LO   = 512;
    localparam int          HI   = 768;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable;
    logic [15:0] fifo_q;
    logic        fifo_rdempty;
    logic        fifo_rdfull;
    logic [9:0]  fifo_rdusedw;
    logic        fifo_rdreq;
    logic        rpi_req;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_sof;
    logic        m_eof;
    logic        m_ready;
    logic        locked;
    logic        overflow;
`ifdef RPI_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  sync_err_cnt;
`endif

    rpi_rx_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_q       (fifo_q),
        .fifo_rdempty (fifo_rdempty),
        .fifo_rdfull  (fifo_rdfull),
        .fifo_rdusedw (fifo_rdusedw),
        .fifo_rdreq   (fifo_rdreq),
        .rpi_req      (rpi_req),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_sof        (m_sof),
        .m_eof        (m_eof),
        .m_ready      (m_ready),
        .locked       (locked),
`ifdef RPI_RX_STATS_EN
        .frame_cnt    (frame_cnt),
        .sync_err_cnt (sync_err_cnt),
`endif
        .overflow     (overflow)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        e;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] fq[$];
    exp_t        exp_q[$];
    int          pos      = -1;
    int          frames_m = 0;
    int          serr_m   = 0;
    bit          inflight_m = 1'b0;
    logic [15:0] inflight_w = '0;
    int          full_m = 0;
    bit          req_m  = 1'b0;
    bit          ovf_m  = 1'b0;
    bit          manual_lvl = 1'b0;
    logic [9:0]  lvl_usedw = '0;
    int          ready_mode = 0;
    int          cyc = 0;
    int          rx_words = 0;
    int          rx_sof = 0;
    int          rx_eof = 0;
    logic [15:0] first_sof = '0;
    logic [15:0] last_eof = '0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame rules at word level: pos -1 = hunting, 0..L-1 = payload index, L = expecting sync.
    task automatic model_word(input logic [15:0] w);
        if (pos < 0) begin
            if (w == SYNC) pos = 0;
        end else if (pos < L) begin
            exp_q.push_back(exp_t'{d: w, s: (pos == 0), e: (pos == L - 1)});
            if (pos == L - 1 && frames_m < 65535) frames_m++;
            pos++;
        end else begin
            if (w == SYNC) begin
                pos = 0;
            end else begin
                pos = -1;
                if (serr_m < 255) serr_m++;
            end
        end
    endtask

    task automatic drive_inputs();
        fifo_rdempty = (fq.size() == 0);
        if (manual_lvl) fifo_rdusedw = lvl_usedw;
        else fifo_rdusedw = (fq.size() > 1023) ? 10'd1023 : 10'(fq.size());
        fifo_rdfull = 1'b0;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic clr_rx();
        rx_words = 0;
        rx_sof   = 0;
        rx_eof   = 0;
    endtask

    // One clock: check at negedge, advance the model for the coming edge, then drive inputs.
    task automatic cycle();
        bit exp_rd;
        bit rd_now;
        @(negedge clk);
        exp_rd = !rst && enable && !fifo_rdempty && (exp_q.size() + int'(inflight_m) < 2);
        chk("fifo_rdreq", 32'(fifo_rdreq), 32'(exp_rd));
        chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        chk("locked", 32'(locked), 32'(pos >= 0));
        chk("rpi_req", 32'(rpi_req), 32'(req_m));
        chk("overflow", 32'(overflow), 32'(ovf_m));
`ifdef RPI_RX_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(frames_m));
        chk("sync_err_cnt", 32'(sync_err_cnt), 32'(serr_m));
`endif
        if (exp_q.size() != 0) begin
            chk("m_data", 32'(m_data), 32'(exp_q[0].d));
            chk("m_sof", 32'(m_sof), 32'(exp_q[0].s));
            chk("m_eof", 32'(m_eof), 32'(exp_q[0].e));
        end
        if (prev_stall) chk("stall_hold", 32'({m_data, m_sof, m_eof}), 32'(prev_out));
        rd_now = fifo_rdreq;
        if (rst) begin
            exp_q.delete();
            pos = -1; inflight_m = 1'b0; full_m = 0; req_m = 1'b0; ovf_m = 1'b0;
            frames_m = 0; serr_m = 0; prev_stall = 1'b0;
        end else begin
            prev_stall = (exp_q.size() != 0) && !m_ready;
            prev_out   = {m_data, m_sof, m_eof};
            if (m_valid && m_ready) begin
                rx_words++;
                if (m_sof) begin rx_sof++; first_sof = m_data; end
                if (m_eof) begin rx_eof++; last_eof = m_data; end
            end
            if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
            if (inflight_m) model_word(inflight_w);
            ovf_m = ovf_m || (full_m >= 1024);
            if (!enable) req_m = 1'b0;
            else if (full_m < LO) req_m = 1'b1;
            else if (full_m >= HI) req_m = 1'b0;
            full_m = (fifo_rdfull ? 1024 : 0) + int'(fifo_rdusedw);
            inflight_m = exp_rd;
            if (exp_rd && fq.size() != 0) inflight_w = fq[0];
        end
        @(posedge clk);
        #1;
        if (rd_now && fq.size() != 0) fifo_q = fq.pop_front();
        cyc++;
        drive_inputs();
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0 || inflight_m || !fifo_rdempty) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk({tag, "_drain_done"}, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic push_frame(input logic [15:0] base, input bit rnd);
        for (int i = 0; i < L; i++) fq.push_back(rnd ? 16'($urandom) : base + 16'(i));
    endtask

    initial begin
        int n;
        int sz;
        rst = 1'b1; enable = 1'b1; fifo_q = '0; fifo_rdempty = 1'b1;
        fifo_rdfull = 1'b0; fifo_rdusedw = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cycle();
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_sof", 32'(m_sof), 32'd0);
        chk("rst_m_eof", 32'(m_eof), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_rpi_req", 32'(rpi_req), 32'd0);
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        rst = 1'b0;

        // Watermark sweep with hysteresis.
        manual_lvl = 1'b1;
        for (int v = 0; v <= 800; v += 25) begin
            lvl_usedw = 10'(v);
            repeat (3) cycle();
            if (v == 600) chk("wm_up_600", 32'(rpi_req), 32'd1);
        end
        chk("wm_top_800", 32'(rpi_req), 32'd0);
        for (int v = 800; v >= 0; v -= 25) begin
            lvl_usedw = 10'(v);
            repeat (3) cycle();
            if (v == 600) chk("wm_down_600", 32'(rpi_req), 32'd0);
        end
        chk("wm_bottom_0", 32'(rpi_req), 32'd1);
        manual_lvl = 1'b0;

        // Lock onto the first sync, discard the junk word before it.
        clr_rx(); ready_mode = 0;
        fq.push_back(16'h1234); fq.push_back(SYNC);
        push_frame(16'h0000, 1'b0);
        fq.push_back(SYNC);
        drain("lock", 2000);
        chk("lock_words", 32'(rx_words), 32'd256);
        chk("lock_sof_cnt", 32'(rx_sof), 32'd1);
        chk("lock_first", 32'(first_sof), 32'h0000);
        chk("lock_eof_cnt", 32'(rx_eof), 32'd1);
        chk("lock_last", 32'(last_eof), 32'h00FF);
        chk("lock_locked", 32'(locked), 32'd1);

        // Sync loss after a full frame, then re-hunt.
        clr_rx();
        push_frame(16'h0100, 1'b0);
        fq.push_back(16'hBEEF);
        drain("sync_loss", 2000);
        chk("loss_words", 32'(rx_words), 32'd256);
        chk("loss_last", 32'(last_eof), 32'h01FF);
        chk("loss_locked", 32'(locked), 32'd0);
`ifdef RPI_RX_STATS_EN
        chk("loss_sync_err_cnt", 32'(sync_err_cnt), 32'd1);
`endif
        fq.push_back(SYNC);
        push_frame(16'h0200, 1'b0);
        fq.push_back(SYNC);
        drain("rehunt", 2000);
        chk("rehunt_words", 32'(rx_words), 32'd512);
        chk("rehunt_locked", 32'(locked), 32'd1);

        // Backpressure: ready one cycle in three.
        clr_rx(); ready_mode = 1;
        push_frame(16'h0000, 1'b1);
        fq.push_back(SYNC);
        drain("bp", 4000);
        chk("bp_words", 32'(rx_words), 32'd256);
        chk("bp_eof_cnt", 32'(rx_eof), 32'd1);
        ready_mode = 0;

        // Overflow is sticky after a single full pulse.
        chk("ovf_clear", 32'(overflow), 32'd0);
        fifo_rdfull = 1'b1;
        cycle();
        repeat (3) cycle();
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (5) cycle();
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Enable drop mid-frame, then resume the same frame.
        clr_rx();
        push_frame(16'h0300, 1'b0);
        fq.push_back(SYNC);
        repeat (60) cycle();
        enable = 1'b0;
        chk("en_rdreq_off", 32'(fifo_rdreq), 32'd0);
        sz = fq.size();
        repeat (10) cycle();
        chk("en_no_reads", 32'(fq.size()), 32'(sz));
        chk("en_rpi_req", 32'(rpi_req), 32'd0);
        chk("en_locked", 32'(locked), 32'd1);
        enable = 1'b1;
        drain("enable", 2000);
        chk("en_words", 32'(rx_words), 32'd256);
        chk("en_sof_cnt", 32'(rx_sof), 32'd1);
        chk("en_eof_cnt", 32'(rx_eof), 32'd1);

        // Reset mid-frame at idx 100.
        clr_rx();
        push_frame(16'h0400, 1'b0);
        n = 0;
        while (pos != 100 && n < 2000) begin cycle(); n++; end
        chk("rst_mid_reach_idx", 32'(n < 2000), 32'd1);
        rst = 1'b1;
        fq.delete();
        cycle();
        rst = 1'b0;
        chk("rmid_m_valid", 32'(m_valid), 32'd0);
        chk("rmid_m_data", 32'(m_data), 32'd0);
        chk("rmid_m_sof", 32'(m_sof), 32'd0);
        chk("rmid_m_eof", 32'(m_eof), 32'd0);
        chk("rmid_locked", 32'(locked), 32'd0);
        chk("rmid_rpi_req", 32'(rpi_req), 32'd0);
        chk("rmid_overflow", 32'(overflow), 32'd0);
        chk("rmid_rdreq", 32'(fifo_rdreq), 32'd0);
        clr_rx();
        for (int i = 0; i < 20; i++) fq.push_back(16'h0480 + 16'(i));
        drain("rmid_nosync", 500);
        chk("rmid_nosync_words", 32'(rx_words), 32'd0);
        chk("rmid_nosync_locked", 32'(locked), 32'd0);
        fq.push_back(SYNC);
        push_frame(16'h0500, 1'b0);
        fq.push_back(SYNC);
        drain("rmid_resync", 2000);
        chk("rmid_resync_words", 32'(rx_words), 32'd256);

        // Randomized traffic: junk, frames, good or bad trailing sync, random ready.
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) fq.push_back(16'($urandom));
            fq.push_back(SYNC);
            push_frame(16'h0000, 1'b1);
            if ($urandom_range(0, 1) == 1) fq.push_back(SYNC);
            else fq.push_back(16'hDEAD);
            drain("rand", 3000);
        end
        chk("end_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
